namuru_time_base_gen: RTL and testbench

Parametrised time base for the namuru GPS correlator. It generates:
- the RF front-end sample clock and the accumulator sample enable from a divide-by-SC_DIV counter;
- the preTIC/TIC pair from a programmable down-counter;
- N_ACC independent accumulation interrupt strobes from programmable down-counters.

Compared with the single-channel predecessor, it adds a global enable, a synchronous resync, a programmable preTIC-to-TIC lead, and a running TIC number.

---
 rtl/namuru_time_base_pkg.sv | 10 +
 rtl/namuru_down_counter.sv | 33 +++
 rtl/namuru_time_base_gen.sv | 105 ++++++++++
 tb/tb_namuru_time_base_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/namuru_time_base_pkg.sv
// Shared defaults for the namuru correlator time base: counter width, sample
// clock ratio and the power-on TIC / accumulation divide values.
package namuru_time_base_pkg;

    localparam int          DEF_CNT_W          = 24;
    localparam int          DEF_SC_DIV         = 7;
    localparam logic [23:0] DEF_TIC_DIVIDE     = 24'h3D08FF;
    localparam logic [23:0] DEF_ACCUM_DIVIDE   = 24'h4E1F;

endpackage

// File: rtl/namuru_down_counter.sv
// Reloading down-counter: counts to zero, then reloads its divide value on the
// next enabled cycle. A load (resync) overrides everything but reset.
module namuru_down_counter
    import namuru_time_base_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic [W-1:0] q,
    output logic         zero
);

    assign zero = (q == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (en) begin
            if (zero) begin
                q <= data;
            end else begin
                q <= q - W'(1);
            end
        end
    end

endmodule

// File: rtl/namuru_time_base_gen.sv
// Correlator time base: sample clock / accumulator sample enable, preTIC and
// delayed TIC with a running TIC number, and N_ACC accumulation strobes.
module namuru_time_base_gen
    import namuru_time_base_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SC_DIV       = DEF_SC_DIV,
    parameter int SC_W         = 4,
    parameter int SC_CLK_PHASE = 0,
    parameter int SC_ACC_PHASE = 3,
    parameter int N_ACC        = 2,
    parameter int TIC_LEAD     = 1,
    parameter int TICN_W       = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   resync,
    input  logic [CNT_W-1:0]       tic_divide,
    input  logic [N_ACC*CNT_W-1:0] accum_divide,
    output logic                   sample_clk,
    output logic                   accum_sample_enable,
    output logic                   pre_tic_enable,
    output logic                   tic_enable,
    output logic [N_ACC-1:0]       accum_enable,
    output logic [CNT_W-1:0]       tic_count,
    output logic [N_ACC*CNT_W-1:0] accum_count,
    output logic [TICN_W-1:0]      tic_number
);

    logic [SC_W-1:0]     sc;
    logic                tic_zero;
    logic [TIC_LEAD-1:0] tic_dly;
    logic [N_ACC-1:0]    acc_zero;

    // Sample counter: modulo SC_DIV, decodes held while frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sc <= '0;
        end else if (resync) begin
            sc <= '0;
        end else if (enable) begin
            if (sc == SC_W'(SC_DIV - 1)) begin
                sc <= '0;
            end else begin
                sc <= sc + SC_W'(1);
            end
        end
    end

    assign sample_clk          = (sc == SC_W'(SC_CLK_PHASE));
    assign accum_sample_enable = (sc == SC_W'(SC_ACC_PHASE));

    namuru_down_counter #(.W(CNT_W)) u_tic_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (enable),
        .load (resync),
        .data (tic_divide),
        .q    (tic_count),
        .zero (tic_zero)
    );

    assign pre_tic_enable = tic_zero & enable;

    // Delay line clears on resync so a preTIC seen in that cycle never becomes a TIC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tic_dly <= '0;
        end else if (resync) begin
            tic_dly <= '0;
        end else if (enable) begin
            tic_dly[0] <= pre_tic_enable;
            for (int i = 1; i < TIC_LEAD; i++) begin
                tic_dly[i] <= tic_dly[i-1];
            end
        end
    end

    assign tic_enable = tic_dly[TIC_LEAD-1] & enable;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tic_number <= '0;
        end else if (resync) begin
            tic_number <= '0;
        end else if (tic_enable) begin
            tic_number <= tic_number + TICN_W'(1);
        end
    end

    for (genvar k = 0; k < N_ACC; k++) begin : g_acc
        namuru_down_counter #(.W(CNT_W)) u_acc_cnt (
            .clk  (clk),
            .rstn (rstn),
            .en   (enable),
            .load (resync),
            .data (accum_divide[k*CNT_W +: CNT_W]),
            .q    (accum_count[k*CNT_W +: CNT_W]),
            .zero (acc_zero[k])
        );
        assign accum_enable[k] = acc_zero[k] & enable;
    end

endmodule

// File: tb/tb_namuru_time_base_gen.sv
// Bench for the time base: directed table, corner sequences and randomized
// traffic against an event-level reference model.
module tb_namuru_time_base_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        resync;
    logic [23:0] tic_divide;
    logic [47:0] accum_divide;

    logic        sample_clk, accum_sample_enable, pre_tic_enable, tic_enable;
    logic [1:0]  accum_enable;
    logic [23:0] tic_count;
    logic [47:0] accum_count;
    logic [31:0] tic_number;

    logic        sample_clk_3, accum_sample_enable_3, pre_tic_enable_3, tic_enable_3;
    logic [1:0]  accum_enable_3;
    logic [23:0] tic_count_3;
    logic [47:0] accum_count_3;
    logic [31:0] tic_number_3;

    always #5 clk = ~clk;

    namuru_time_base_gen #(
        .CNT_W(24), .SC_DIV(7), .SC_W(4), .SC_CLK_PHASE(0), .SC_ACC_PHASE(3),
        .N_ACC(2), .TIC_LEAD(1), .TICN_W(32)
    ) dut1 (
        .clk(clk), .rstn(rstn), .enable(enable), .resync(resync),
        .tic_divide(tic_divide), .accum_divide(accum_divide),
        .sample_clk(sample_clk), .accum_sample_enable(accum_sample_enable),
        .pre_tic_enable(pre_tic_enable), .tic_enable(tic_enable),
        .accum_enable(accum_enable), .tic_count(tic_count),
        .accum_count(accum_count), .tic_number(tic_number)
    );

    namuru_time_base_gen #(
        .CNT_W(24), .SC_DIV(7), .SC_W(4), .SC_CLK_PHASE(0), .SC_ACC_PHASE(3),
        .N_ACC(2), .TIC_LEAD(3), .TICN_W(32)
    ) dut3 (
        .clk(clk), .rstn(rstn), .enable(enable), .resync(resync),
        .tic_divide(tic_divide), .accum_divide(accum_divide),
        .sample_clk(sample_clk_3), .accum_sample_enable(accum_sample_enable_3),
        .pre_tic_enable(pre_tic_enable_3), .tic_enable(tic_enable_3),
        .accum_enable(accum_enable_3), .tic_count(tic_count_3),
        .accum_count(accum_count_3), .tic_number(tic_number_3)
    );

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Event-level view: a modulo-7 phase, remaining-cycles-to-zero per
    // counter, and the pending preTIC history for each TIC lead.
    int          m_sc, m_tic;
    int          m_acc[2];
    bit          q1[$];
    bit          q3[$];
    logic [31:0] m_tn1, m_tn3;

    task automatic model_reset();
        m_sc = 0; m_tic = 0; m_acc[0] = 0; m_acc[1] = 0;
        q1.delete(); q3.delete();
        q1.push_back(1'b0);
        repeat (3) q3.push_back(1'b0);
        m_tn1 = '0; m_tn3 = '0;
    endtask

    task automatic model_compare();
        logic [47:0] e_acc;
        logic [1:0]  e_acc_en;
        for (int k = 0; k < 2; k++) begin
            e_acc[k*24 +: 24] = m_acc[k][23:0];
            e_acc_en[k]       = enable && (m_acc[k] == 0);
        end
        chk("sample_clk", sample_clk, m_sc == 0);
        chk("accum_sample_enable", accum_sample_enable, m_sc == 3);
        chk("pre_tic_enable", pre_tic_enable, enable && (m_tic == 0));
        chk("tic_enable_lead1", tic_enable, enable && q1[0]);
        chk("tic_enable_lead3", tic_enable_3, enable && q3[0]);
        chk("accum_enable", accum_enable, e_acc_en);
        chk("tic_count", tic_count, m_tic);
        chk("accum_count", accum_count, e_acc);
        chk("tic_number_lead1", tic_number, m_tn1);
        chk("tic_number_lead3", tic_number_3, m_tn3);
    endtask

    task automatic model_advance();
        bit pre, te1, te3;
        if (!rstn) begin
            model_reset();
        end else if (resync) begin
            m_sc = 0;
            m_tic = int'(tic_divide);
            for (int k = 0; k < 2; k++) m_acc[k] = int'(accum_divide[k*24 +: 24]);
            q1.delete(); q3.delete();
            q1.push_back(1'b0);
            repeat (3) q3.push_back(1'b0);
            m_tn1 = '0; m_tn3 = '0;
        end else if (enable) begin
            pre = (m_tic == 0);
            te1 = q1[0];
            te3 = q3[0];
            m_sc  = (m_sc + 1) % 7;
            m_tic = (m_tic == 0) ? int'(tic_divide) : m_tic - 1;
            for (int k = 0; k < 2; k++)
                m_acc[k] = (m_acc[k] == 0) ? int'(accum_divide[k*24 +: 24]) : m_acc[k] - 1;
            void'(q1.pop_front()); q1.push_back(pre);
            void'(q3.pop_front()); q3.push_back(pre);
            m_tn1 = m_tn1 + 32'(te1);
            m_tn3 = m_tn3 + 32'(te3);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          cyc;
        logic        pre;
        logic        te1;
        logic        te3;
        logic [1:0]  acc;
        logic        sclk;
        logic        ase;
        logic [31:0] tn1;
    } vec_t;

    vec_t tbl[14];
    int   tbl_i  = 0;
    bit   tbl_on = 1'b0;

    // ---------------- per-cycle driver ----------------
    int          cyc = 0;
    int          s_cyc;
    logic        s_sclk, s_ase, s_pre, s_te1, s_te3;
    logic [1:0]  s_acc;
    logic [23:0] s_tc;
    logic [31:0] s_tn1, s_tn3;

    task automatic tick();
        @(negedge clk);
        s_cyc = cyc;
        s_sclk = sample_clk; s_ase = accum_sample_enable; s_pre = pre_tic_enable;
        s_te1 = tic_enable; s_te3 = tic_enable_3; s_acc = accum_enable;
        s_tc = tic_count; s_tn1 = tic_number; s_tn3 = tic_number_3;
        model_compare();
        if (tbl_on && tbl_i < 14 && tbl[tbl_i].cyc == cyc) begin
            chk($sformatf("tbl%0d_pre", cyc), s_pre, tbl[tbl_i].pre);
            chk($sformatf("tbl%0d_tic1", cyc), s_te1, tbl[tbl_i].te1);
            chk($sformatf("tbl%0d_tic3", cyc), s_te3, tbl[tbl_i].te3);
            chk($sformatf("tbl%0d_acc", cyc), s_acc, tbl[tbl_i].acc);
            chk($sformatf("tbl%0d_sclk", cyc), s_sclk, tbl[tbl_i].sclk);
            chk($sformatf("tbl%0d_ase", cyc), s_ase, tbl[tbl_i].ase);
            chk($sformatf("tbl%0d_tnum", cyc), s_tn1, tbl[tbl_i].tn1);
            tbl_i++;
        end
        @(posedge clk);
        model_advance();
        #1;
        cyc++;
    endtask

    task automatic run_to_pretic();
        for (int i = 0; i < 50 && m_tic != 0; i++) tick();
        chk("pretic_reached", m_tic == 0, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last_s, last_a, rc;
        logic [31:0] tn_before;
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];

        //        cyc pre te1 te3 acc    sclk ase tn1
        tbl[0]  = '{0,  1, 0, 0, 2'b11, 1, 0, 0};
        tbl[1]  = '{1,  0, 1, 0, 2'b00, 0, 0, 0};
        tbl[2]  = '{2,  0, 0, 0, 2'b00, 0, 0, 1};
        tbl[3]  = '{3,  0, 0, 1, 2'b01, 0, 1, 1};
        tbl[4]  = '{5,  0, 0, 0, 2'b10, 0, 0, 1};
        tbl[5]  = '{10, 1, 0, 0, 2'b10, 0, 1, 1};
        tbl[6]  = '{11, 0, 1, 0, 2'b00, 0, 0, 1};
        tbl[7]  = '{12, 0, 0, 0, 2'b01, 0, 0, 2};
        tbl[8]  = '{13, 0, 0, 1, 2'b00, 0, 0, 2};
        tbl[9]  = '{15, 0, 0, 0, 2'b11, 0, 0, 2};
        tbl[10] = '{20, 1, 0, 0, 2'b10, 0, 0, 2};
        tbl[11] = '{21, 0, 1, 0, 2'b01, 1, 0, 2};
        tbl[12] = '{22, 0, 0, 0, 2'b00, 0, 0, 3};
        tbl[13] = '{23, 0, 0, 1, 2'b00, 0, 0, 3};

        // Reset state, enable low.
        rstn = 1'b0; enable = 1'b0; resync = 1'b0;
        tic_divide = 24'd9; accum_divide = {24'd4, 24'd2};
        model_reset();
        repeat (3) tick();
        chk("reset_sample_clk", s_sclk, 1'b1);
        chk("reset_pre_tic_gated", s_pre, 1'b0);

        // Release reset, run the directed table.
        rstn = 1'b1; enable = 1'b1; cyc = 0; tbl_on = 1'b1;
        repeat (24) tick();
        tbl_on = 1'b0;
        chk("tbl_entries_visited", tbl_i, 14);

        // Sample clock / accum sample enable spacing over 100 cycles.
        last_s = -1; last_a = -1;
        repeat (100) begin
            tick();
            if (s_sclk) begin
                if (last_s >= 0) chk("sclk_spacing", s_cyc - last_s, 7);
                last_s = s_cyc;
            end
            if (s_ase) begin
                if (last_a >= 0) chk("ase_spacing", s_cyc - last_a, 7);
                last_a = s_cyc;
            end
        end

        // Channel 0 divide changed mid-period applies after its next zero.
        accum_divide = {24'd4, 24'd2};
        resync = 1'b1;
        rc = cyc;
        tick();
        resync = 1'b0;
        exp_q = {rc + 3, rc + 6, rc + 12};
        got_q.delete();
        repeat (13) begin
            tick();
            if (s_acc[0]) got_q.push_back(s_cyc);
            if (s_cyc == rc + 3) accum_divide[23:0] = 24'd5;
        end
        chk("acc0_pulse_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("acc0_pulse%0d_cycle", i), got_q[i] - rc, exp_q[i] - rc);

        // Freeze for 4 cycles starting on a preTIC cycle.
        run_to_pretic();
        tn_before = m_tn1;
        enable = 1'b0;
        repeat (4) begin
            tick();
            chk("freeze_pre", s_pre, 1'b0);
            chk("freeze_tic", s_te1, 1'b0);
            chk("freeze_acc", s_acc, 2'b00);
            chk("freeze_tic_count", s_tc, 24'd0);
        end
        enable = 1'b1;
        tick();
        chk("unfreeze_pre", s_pre, 1'b1);
        chk("unfreeze_tic_early", s_te1, 1'b0);
        tick();
        chk("unfreeze_tic", s_te1, 1'b1);
        tick();
        chk("unfreeze_tic_number", s_tn1, tn_before + 32'd1);

        // Resync coinciding with preTIC: no TIC may follow.
        run_to_pretic();
        resync = 1'b1;
        tick();
        chk("resync_pre_visible", s_pre, 1'b1);
        resync = 1'b0;
        tick();
        chk("resync_tic_count", s_tc, 24'd9);
        chk("resync_tic_number3", s_tn3, 32'd0);
        chk("resync_tic_number1", s_tn1, 32'd0);
        chk("resync_sc_zero", s_sclk, 1'b1);
        repeat (6) begin
            tick();
            chk("resync_no_tic3", s_te3, 1'b0);
        end

        // Randomized traffic.
        repeat (400) begin
            enable = ($urandom_range(0, 9) != 0);
            resync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) tic_divide = 24'($urandom_range(0, 12));
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 7) == 0) accum_divide[k*24 +: 24] = 24'($urandom_range(0, 6));
            tick();
        end

        // Asynchronous reset mid-period.
        enable = 1'b1; resync = 1'b1;
        tic_divide = 24'd3; accum_divide = {24'd5, 24'd5};
        tick();
        resync = 1'b0;
        repeat (6) tick();
        chk("pre_reset_tic_number", m_tn1, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_tic_count", tic_count, 24'd0);
        chk("async_accum_count", accum_count, 48'd0);
        chk("async_tic_number", tic_number, 32'd0);
        chk("async_tic_number3", tic_number_3, 32'd0);
        model_reset();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
